// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the serial_adder block
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

  localparam int SA_WIDTH = 8;

  // Bit-counter width; never below one bit so the smallest legal WIDTH still has a counter.
  function automatic int sa_cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int SA_CNT_W = sa_cnt_w(SA_WIDTH);

endpackage

// File: rtl/serial_adder_fa_cell.sv
// rtl/serial_adder_fa_cell.sv - combinational 3:2 counter (full-adder cell)
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y,
  output logic z
);

  assign y = (a & b) | (a & c) | (b & c);
  assign z = a ^ b ^ c;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder; SERIAL_ADDER_SUB_EN adds a subtract input
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int                CNT_W    = sa_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_e         state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              fa_y, fa_z;
  logic [WIDTH-1:0]  b_load;
  logic              carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: invert B and inject the +1 through the initial carry.
  assign b_load     = sub ? ~b_in : b_in;
  assign carry_load = sub;
`else
  assign b_load     = b_in;
  assign carry_load = 1'b0;
`endif

  fa_cell u_fa_cell (
    .a (a_q[0]),
    .b (b_q[0]),
    .c (carry_q),
    .y (fa_y),
    .z (fa_z)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sum_d   = {fa_z, sum_q[WIDTH-1:1]};
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = fa_y;
        if (cnt_q == CNT_LAST) begin
          // Counter parks at its last value instead of wrapping.
          cout_d  = fa_y;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

  a_busy_done_excl: assert property (@(posedge clk) !(busy && done));

endmodule
